// File: rtl/master_cmd_port_pkg.sv
// master_cmd_port_pkg
// Shared definitions for the master command port:
//   - FSM state encoding
//   - burst_mode codes and their mapping to a beat count
//   - width and position of the slave-select field inside the command address
package master_cmd_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_XFER  = 3'd2,
        ST_SPLIT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // burst_mode codes; every other code is treated as a single beat
    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_8      = 3'd1;
    localparam logic [2:0] BURST_16     = 3'd2;

    // Wide enough to hold the largest beat count (16)
    localparam int BEAT_CNT_W = 5;

    // The slave select sits in the top SLV_SEL_W bits of the command address;
    // the local address occupies the remaining low bits starting at bit 0.
    localparam int SLV_SEL_W = 2;

    function automatic int slv_sel_lsb(input int addr_w);
        return addr_w - SLV_SEL_W;
    endfunction

    function automatic logic [BEAT_CNT_W-1:0] beats_for_mode(input logic [2:0] mode);
        logic [BEAT_CNT_W-1:0] beats;
        case (mode)
            BURST_8:  beats = 5'd8;
            BURST_16: beats = 5'd16;
            default:  beats = 5'd1;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/master_cmd_port_burst_addr_gen.sv
// burst_addr_gen
// Holds the beat counter plus the running beat address and write data.
// The address wraps inside the local address space, so the slave never changes.
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   load             capture start address/data/beat total, beat index -> 0
//   advance          current beat completed, step to the next one
//   start_addr       first local address
//   start_data       first write data value
//   beat_total       number of beats in the burst
//   beat_addr        local address of the current beat
//   beat_wdata       write data of the current beat
//   last_beat        current beat is the final one of the burst
module burst_addr_gen
    import master_cmd_port_pkg::*;
#(
    parameter int LADDR_W = 12,
    parameter int DATA_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    input  logic [LADDR_W-1:0]    start_addr,
    input  logic [DATA_W-1:0]     start_data,
    input  logic [BEAT_CNT_W-1:0] beat_total,
    output logic [LADDR_W-1:0]    beat_addr,
    output logic [DATA_W-1:0]     beat_wdata,
    output logic                  last_beat
);

    logic [BEAT_CNT_W-1:0] beat_idx_r;
    logic [BEAT_CNT_W-1:0] beat_total_r;
    logic [LADDR_W-1:0]    addr_r;
    logic [DATA_W-1:0]     data_r;

    // Beat counter with running address and data; all wrap naturally at their width
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_idx_r   <= {BEAT_CNT_W{1'b0}};
            beat_total_r <= {BEAT_CNT_W{1'b0}};
            addr_r       <= {LADDR_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
        end else if (load) begin
            beat_idx_r   <= {BEAT_CNT_W{1'b0}};
            beat_total_r <= beat_total;
            addr_r       <= start_addr;
            data_r       <= start_data;
        end else if (advance) begin
            beat_idx_r   <= beat_idx_r + BEAT_CNT_W'(1);
            addr_r       <= addr_r + LADDR_W'(1);
            data_r       <= data_r + DATA_W'(1);
        end else begin
            beat_idx_r   <= beat_idx_r;
            beat_total_r <= beat_total_r;
            addr_r       <= addr_r;
            data_r       <= data_r;
        end
    end

    assign beat_addr  = addr_r;
    assign beat_wdata = data_r;
    // After reset beat_total_r is 0, so total-1 never matches index 0
    assign last_beat  = (beat_idx_r == (beat_total_r - BEAT_CNT_W'(1)));

endmodule

// File: rtl/master_cmd_port.sv
// master_cmd_port
// Bus master that turns a single command strobe into a 1/8/16-beat read or
// write burst, handling arbitration (grant), split responses and grant loss.
// Ports:
//   clk, reset                     clock, synchronous active-low reset
//   enable, read_en, burst_mode    command strobe, direction, beat-count code
//   data_in, addr_in               first write data, {slave_sel, start address}
//   request / grant                arbitration request and bus grant
//   bus_valid, bus_write           beat valid and direction
//   bus_slave_sel, bus_addr        current beat target
//   bus_wdata                      current beat write data
//   bus_ready, bus_rdata           beat accept and read data (same cycle)
//   bus_split, split_resume        split response and its release
//   rd_data, rd_valid              registered read data and 1-cycle strobe
//   done, busy                     end-of-transaction pulse, not-idle flag
module master_cmd_port
    import master_cmd_port_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   read_en,
    input  logic [2:0]             burst_mode,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [ADDR_W-1:0]      addr_in,
    output logic                   request,
    input  logic                   grant,
    output logic                   bus_valid,
    output logic                   bus_write,
    output logic [SLV_SEL_W-1:0]   bus_slave_sel,
    output logic [ADDR_W-3:0]      bus_addr,
    output logic [DATA_W-1:0]      bus_wdata,
    input  logic                   bus_ready,
    input  logic [DATA_W-1:0]      bus_rdata,
    input  logic                   bus_split,
    input  logic                   split_resume,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   done,
    output logic                   busy
);

    localparam int LADDR_W = ADDR_W - SLV_SEL_W;
    localparam int SEL_LSB = slv_sel_lsb(ADDR_W);

    state_e                  state_r;
    logic                    read_r;
    logic [SLV_SEL_W-1:0]    slave_sel_r;
    logic                    request_r;
    logic                    bus_valid_r;
    logic                    bus_write_r;
    logic [DATA_W-1:0]       rd_data_r;
    logic                    rd_valid_r;
    logic                    done_r;
    logic                    busy_r;

    logic                    load_s;
    logic                    hs_s;
    logic                    last_beat_s;
    logic [LADDR_W-1:0]      beat_addr_s;
    logic [DATA_W-1:0]       beat_wdata_s;

    // A command is accepted only in IDLE; a beat completes on ready while valid
    assign load_s = (state_r == ST_IDLE) && enable;
    assign hs_s   = (state_r == ST_XFER) && bus_ready;

    burst_addr_gen #(
        .LADDR_W (LADDR_W),
        .DATA_W  (DATA_W)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .advance    (hs_s),
        .start_addr (addr_in[LADDR_W-1:0]),
        .start_data (data_in),
        .beat_total (beats_for_mode(burst_mode)),
        .beat_addr  (beat_addr_s),
        .beat_wdata (beat_wdata_s),
        .last_beat  (last_beat_s)
    );

    // Transaction FSM; outputs are registered alongside the state so they track it exactly
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            read_r      <= 1'b0;
            slave_sel_r <= {SLV_SEL_W{1'b0}};
            request_r   <= 1'b0;
            bus_valid_r <= 1'b0;
            bus_write_r <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
            rd_valid_r  <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        read_r      <= read_en;
                        slave_sel_r <= addr_in[SEL_LSB +: SLV_SEL_W];
                        request_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (grant) begin
                        bus_valid_r <= 1'b1;
                        bus_write_r <= ~read_r;
                        state_r     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // A completed beat wins over split and grant loss in the same cycle
                    if (bus_ready) begin
                        if (read_r) begin
                            rd_data_r  <= bus_rdata;
                            rd_valid_r <= 1'b1;
                        end
                        if (last_beat_s) begin
                            bus_valid_r <= 1'b0;
                            bus_write_r <= 1'b0;
                            request_r   <= 1'b0;
                            done_r      <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end else if (bus_split) begin
                        bus_valid_r <= 1'b0;
                        bus_write_r <= 1'b0;
                        state_r     <= ST_SPLIT;
                    end else if (!grant) begin
                        bus_valid_r <= 1'b0;
                        bus_write_r <= 1'b0;
                        state_r     <= ST_REQ;
                    end
                end
                ST_SPLIT: begin
                    if (split_resume) begin
                        bus_valid_r <= 1'b1;
                        bus_write_r <= ~read_r;
                        state_r     <= ST_XFER;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    request_r   <= 1'b0;
                    bus_valid_r <= 1'b0;
                    bus_write_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign request       = request_r;
    assign bus_valid     = bus_valid_r;
    assign bus_write     = bus_write_r;
    assign bus_slave_sel = slave_sel_r;
    assign bus_addr      = beat_addr_s;
    assign bus_wdata     = beat_wdata_s;
    assign rd_data       = rd_data_r;
    assign rd_valid      = rd_valid_r;
    assign done          = done_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_master_cmd_port.sv
// tb_master_cmd_port
// Drives directed and random commands into master_cmd_port while acting as
// arbiter and bus slave. Expected beats are computed from the command alone
// (start + k, data + k, beat count from the mode) and compared as they appear.
module tb_master_cmd_port;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        read_en;
    logic [2:0]  burst_mode;
    logic [7:0]  data_in;
    logic [13:0] addr_in;
    logic        request;
    logic        grant;
    logic        bus_valid;
    logic        bus_write;
    logic [1:0]  bus_slave_sel;
    logic [11:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ready;
    logic [7:0]  bus_rdata;
    logic        bus_split;
    logic        split_resume;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    master_cmd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .read_en       (read_en),
        .burst_mode    (burst_mode),
        .data_in       (data_in),
        .addr_in       (addr_in),
        .request       (request),
        .grant         (grant),
        .bus_valid     (bus_valid),
        .bus_write     (bus_write),
        .bus_slave_sel (bus_slave_sel),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .bus_split     (bus_split),
        .split_resume  (split_resume),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .done          (done),
        .busy          (busy)
    );

    task automatic chk(input string name, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", name, tag, obs, exp);
        end
    endtask

    function automatic int beats_of(input logic [2:0] mode);
        if (mode == 3'd1) return 8;
        if (mode == 3'd2) return 16;
        return 1;
    endfunction

    task automatic check_all_zero(input string name);
        chk(name, "request",   32'(request),       32'd0);
        chk(name, "bus_valid", 32'(bus_valid),     32'd0);
        chk(name, "bus_write", 32'(bus_write),     32'd0);
        chk(name, "slave_sel", 32'(bus_slave_sel), 32'd0);
        chk(name, "bus_addr",  32'(bus_addr),      32'd0);
        chk(name, "bus_wdata", 32'(bus_wdata),     32'd0);
        chk(name, "rd_data",   32'(rd_data),       32'd0);
        chk(name, "rd_valid",  32'(rd_valid),      32'd0);
        chk(name, "done",      32'(done),          32'd0);
        chk(name, "busy",      32'(busy),          32'd0);
    endtask

    task automatic check_idle(input string name);
        chk(name, "idle_request", 32'(request),   32'd0);
        chk(name, "idle_valid",   32'(bus_valid), 32'd0);
        chk(name, "idle_done",    32'(done),      32'd0);
        chk(name, "idle_busy",    32'(busy),      32'd0);
        chk(name, "idle_rdvalid", 32'(rd_valid),  32'd0);
    endtask

    // One complete command. split_beat/drop_beat/reset_beat = -1 disables that event.
    task automatic run_txn(input string name, input bit rd, input logic [2:0] mode,
                           input logic [13:0] addr, input logic [7:0] data, input int gap,
                           input int split_beat, input int drop_beat, input int reset_beat,
                           input bit rand_split);
        int         n;
        int         k;
        int         gap_cnt;
        int         split_wait;
        int         drop_wait;
        bit         hs_prev;
        bit         hs_was;
        bit         split_used;
        bit         drop_used;
        bit         finished;
        bit         aborted;
        bit         first;
        logic [7:0] rdata_prev;
        n = beats_of(mode);
        k = 0; gap_cnt = 0; split_wait = 0; drop_wait = 0;
        hs_prev = 1'b0; split_used = 1'b0; drop_used = 1'b0;
        finished = 1'b0; aborted = 1'b0; first = 1'b1;
        rdata_prev = 8'd0;

        enable = 1'b1; read_en = rd; burst_mode = mode; addr_in = addr; data_in = data;
        grant = 1'b1; bus_ready = 1'b0; bus_split = 1'b0; split_resume = 1'b0;
        @(posedge clk); #1;
        chk(name, "req_latency",  32'(request),   32'd1);
        chk(name, "busy_latency", 32'(busy),      32'd1);
        chk(name, "valid_in_req", 32'(bus_valid), 32'd0);
        // Conflicting command held on the inputs while busy must be ignored
        enable = 1'b1; read_en = ~rd; burst_mode = 3'd2; addr_in = ~addr; data_in = ~data;

        for (int cyc = 0; cyc < 800 && !finished; cyc++) begin
            @(posedge clk); #1;
            if (first) begin
                chk(name, "valid_latency", 32'(bus_valid), 32'd1);
                first = 1'b0;
            end
            hs_was  = hs_prev;
            hs_prev = 1'b0;
            if (hs_was && rd) begin
                chk(name, "rd_valid", 32'(rd_valid), 32'd1);
                chk(name, "rd_data",  32'(rd_data),  32'(rdata_prev));
            end else begin
                chk(name, "rd_valid_quiet", 32'(rd_valid), 32'd0);
            end
            bus_ready = 1'b0; bus_split = 1'b0; split_resume = 1'b0; grant = 1'b1;
            enable = 1'($urandom_range(0, 1));
            if (done) begin
                enable = 1'b0;
                chk(name, "beat_count",   32'(k),       32'(n));
                chk(name, "done_request", 32'(request), 32'd0);
                chk(name, "done_busy",    32'(busy),    32'd1);
                chk(name, "done_latency", 32'(hs_was),  32'd1);
                finished = 1'b1;
            end else if (split_wait > 0) begin
                chk(name, "split_valid",   32'(bus_valid), 32'd0);
                chk(name, "split_request", 32'(request),   32'd1);
                split_wait--;
                split_resume = (split_wait == 0);
            end else if (drop_wait > 0) begin
                chk(name, "drop_valid",   32'(bus_valid), 32'd0);
                chk(name, "drop_request", 32'(request),   32'd1);
                drop_wait--;
                grant = (drop_wait == 0);
            end else if (bus_valid) begin
                chk(name, "beat_slave", 32'(bus_slave_sel), 32'(addr[13:12]));
                chk(name, "beat_addr",  32'(bus_addr),      32'((int'(addr[11:0]) + k) % 4096));
                chk(name, "beat_write", 32'(bus_write),     32'(!rd));
                chk(name, "beat_req",   32'(request),       32'd1);
                if (!rd) chk(name, "beat_wdata", 32'(bus_wdata), 32'((int'(data) + k) % 256));
                if (reset_beat == k) begin
                    reset = 1'b0;
                    enable = 1'b1;
                    @(posedge clk); #1;
                    check_all_zero({name, "_rst"});
                    reset = 1'b1;
                    enable = 1'b0;
                    for (int j = 0; j < 4; j++) begin
                        @(posedge clk); #1;
                        check_idle({name, "_after_rst"});
                    end
                    finished = 1'b1;
                    aborted  = 1'b1;
                end else if (split_beat == k && !split_used) begin
                    bus_split = 1'b1; split_used = 1'b1; split_wait = 3;
                end else if (drop_beat == k && !drop_used) begin
                    grant = 1'b0; drop_used = 1'b1; drop_wait = 3;
                end else if (gap_cnt >= gap) begin
                    bus_ready  = 1'b1;
                    bus_rdata  = 8'($urandom);
                    rdata_prev = bus_rdata;
                    if (rand_split) bus_split = 1'($urandom_range(0, 1));
                    hs_prev = 1'b1;
                    gap_cnt = 0;
                    k++;
                end else begin
                    gap_cnt++;
                end
            end else begin
                chk(name, "unexpected_valid_low", 32'(bus_valid), 32'd1);
            end
        end
        chk(name, "finished", 32'(finished), 32'd1);
        enable = 1'b0; bus_ready = 1'b0; bus_split = 1'b0; split_resume = 1'b0; grant = 1'b1;
        if (!aborted) begin
            @(posedge clk); #1;
            check_idle({name, "_post"});
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; read_en = 1'b0; burst_mode = 3'd0;
        data_in = 8'd0; addr_in = 14'd0; grant = 1'b0; bus_ready = 1'b0;
        bus_rdata = 8'd0; bus_split = 1'b0; split_resume = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("idle_after_reset");

        run_txn("single_write", 1'b0, 3'd0, 14'b01_010101010101, 8'hAA, 0, -1, -1, -1, 1'b0);
        run_txn("burst16_write", 1'b0, 3'd2, 14'd111, 8'h10, 0, -1, -1, -1, 1'b0);
        run_txn("burst8_read_gaps", 1'b1, 3'd1, 14'd4094, 8'h00, 2, -1, -1, -1, 1'b0);
        run_txn("split_write", 1'b0, 3'd0, 14'd1001, 8'h5C, 0, 0, -1, -1, 1'b0);
        run_txn("grant_loss", 1'b0, 3'd1, 14'h2FFC, 8'hF9, 0, -1, 3, -1, 1'b0);
        run_txn("reset_mid_burst", 1'b0, 3'd1, 14'h1234, 8'h40, 1, -1, -1, 5, 1'b0);

        for (int t = 0; t < 8; t++) begin
            run_txn($sformatf("random_%0d", t), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    14'($urandom), 8'($urandom), $urandom_range(0, 2),
                    ($urandom_range(0, 2) == 0) ? 0 : -1,
                    ($urandom_range(0, 2) == 0) ? 0 : -1,
                    -1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/master_cmd_port.md
MASTER_CMD_PORT -- requirements
Module: master_cmd_port

Interface
REQ-001 Parameter DATA_W, default 8, data width.
REQ-002 Parameter ADDR_W, default 14, command address width; the upper 2 bits select the slave and the lower ADDR_W-2 bits are the local address.
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous reset, active-low.
REQ-006 enable  in  1  command strobe from the test controller.
REQ-007 read_en  in  1  command type: 1 = read, 0 = write.
REQ-008 burst_mode  in  3  beat count: 0 = 1 beat, 1 = 8 beats, 2 = 16 beats, 3..7 = 1 beat.
REQ-009 data_in  in  DATA_W  first write data value.
REQ-010 addr_in  in  ADDR_W  {slave_sel, start local address}.
REQ-011 request  out  1  high from command acceptance until the transaction ends; the controller and the arbiter observe it.
REQ-012 grant  in  1  bus grant from the arbiter.
REQ-013 bus_valid, bus_write  out  1 each  beat valid and beat direction.
REQ-014 bus_slave_sel  out  2; bus_addr  out  ADDR_W-2; bus_wdata  out  DATA_W.
REQ-015 bus_ready  in  1  beat accepted; read data is valid in the same cycle.
REQ-016 bus_rdata  in  DATA_W; bus_split  in  1; split_resume  in  1.
REQ-017 rd_data  out  DATA_W; rd_valid  out  1; done  out  1; busy  out  1.

Function
REQ-018 The FSM has five states: IDLE, REQ, XFER, SPLIT, DONE.
REQ-019 IDLE: when enable=1, the block latches read_en, the beat count, data_in and addr_in, and moves to REQ; request is high from the next cycle.
REQ-020 While not in IDLE, enable is ignored.
REQ-021 REQ: request=1 and bus_valid=0; grant=1 moves the FSM to XFER on the next edge.
REQ-022 XFER: bus_valid=1, bus_write=~read_en, and bus_slave_sel and bus_addr show the current beat.
REQ-023 XFER beat completion is the cycle in which bus_valid and bus_ready are both 1.
REQ-024 Beat k (k = 0..N-1) uses bus_addr = start + k, modulo 2^(ADDR_W-2); the wrap stays on the same slave and bus_slave_sel stays fixed.
REQ-025 Beat k write data is bus_wdata = data_in + k, modulo 2^DATA_W.
REQ-026 On a read beat completion, rd_data is loaded with bus_rdata and rd_valid pulses for 1 cycle, both registered on the next cycle.
REQ-027 After the last beat completes, the FSM moves to DONE.
REQ-028 DONE lasts 1 cycle with done=1, and request drops to 0 in DONE.
REQ-029 After DONE the FSM returns to IDLE.
REQ-030 In XFER, if bus_split=1 and bus_ready=0, the FSM moves to SPLIT; the beat index is unchanged.
REQ-031 SPLIT: bus_valid=0 and request=1; split_resume=1 moves the FSM to XFER and re-issues the same beat.
REQ-032 In XFER, if grant=0 and no handshake occurs in that cycle, the FSM returns to REQ and keeps the beat index.
REQ-033 bus_ready and bus_split high in the same cycle counts as a completed beat; split is ignored.
REQ-034 busy=1 in every state except IDLE.
REQ-035 Latency: enable at edge t gives request=1 after edge t+1; with grant already high, bus_valid=1 after edge t+2.

Reset
REQ-036 When reset=0 at a clock edge, the FSM goes to IDLE and every output goes to 0: request, bus_valid, bus_write, bus_slave_sel, bus_addr, bus_wdata, rd_data, rd_valid, done, busy.
REQ-037 Reset during a transaction aborts it with no done pulse; the latched command and the beat counter are cleared.

Structure
REQ-038 A shared package holds the state encoding, the burst_mode codes, the function mapping burst_mode to beat count, and the slave-select field width and position.
REQ-039 One sub-module, burst_addr_gen, holds the beat counter and the address and data increments; its outputs are the current beat address, write data and last-beat flag.

Verification
REQ-040 Single write: enable, read_en=0, mode 0, addr 14'b01_010101010101, data 8'hAA, grant tied high -> one beat on slave 1, bus_addr 1365, bus_wdata 8'hAA; done 1 cycle after the handshake; request low in the DONE cycle.
REQ-041 Burst write of 16: mode 2, addr 111, data 8'h10 -> addresses 111..126, data 8'h10..8'h1F, 16 handshakes, then done.
REQ-042 Burst read of 8 with 2-cycle bus_ready gaps: mode 1, addr 4094 on slave 0 -> addresses 4094, 4095, 0..5; 8 rd_valid pulses, each rd_data equal to bus_rdata at its handshake.
REQ-043 Split: bus_split on beat 0 of a write to address 1001 -> bus_valid low and request high until split_resume; after split_resume the same beat is re-issued, followed by done.
REQ-044 Grant loss: grant dropped at beat 3 of an 8-beat burst -> the FSM returns to REQ; when grant returns it resumes at beat 3 with no lost or duplicated beats.
REQ-045 Reset mid-burst at beat 5, plus enable pulsed while busy -> all outputs 0 next cycle, no done pulse; enable pulses while busy start no new transaction.
